// File: rtl/serial_pkg.sv
// Shared definitions for the asynchronous serial link (transmitter and the
// matching receiver).
//   - State encoding of the byte-level FSMs.
//   - Default bit time (CLK_DIV) and data width (DATA_W).
package serial_pkg;

  // Default number of clk cycles per serial bit.
  localparam int DEFAULT_CLK_DIV = 16;

  // Default number of data bits per frame.
  localparam int DEFAULT_DATA_W  = 8;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } serial_state_e;

endpackage

// File: rtl/bit_timer.sv
// bit_timer: free-running bit-period counter for the serial link.
//   clk      - system clock, posedge
//   rst      - synchronous active-high reset
//   clear    - synchronous clear of the cycle counter
//   bit_tick - high while the counter sits at CLK_DIV-1 (last cycle of a bit)
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter wraps on its own at LAST, so consecutive bits need no clear.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = (cnt_q == LAST);

endmodule

// File: rtl/serial_byte_tx.sv
// serial_byte_tx: parallel-to-serial byte transmitter.
// Frame layout: start bit (0), DATA_W data bits LSB first, stop bit (1).
// Each bit lasts CLK_DIV clk cycles.
//   clk      - system clock, posedge
//   rst      - synchronous active-high reset
//   tx_start - one-cycle send request, accepted only while busy=0
//   tx_data  - word to send, sampled on the accepting edge
//   tx       - serial line, idles high (registered)
//   busy     - high from the accepting edge until frame end (registered)
//   tx_done  - one-cycle pulse at frame completion (registered)
module serial_byte_tx
  import serial_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int DATA_W  = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  serial_state_e     state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              tx_done_q, tx_done_d;
  logic              timer_clear;
  logic              bit_tick;
  logic [DATA_W-1:0] shift_next;

  // Holding the timer cleared while idle makes every bit period start
  // exactly at the accepting edge.
  bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .bit_tick (bit_tick)
  );

  assign shift_next = shift_q >> 1;

  // Outputs are registered, so tx_d carries the level the line must show
  // after the edge on which the state changes.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    tx_done_d   = 1'b0;
    timer_clear = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d        = 1'b1;
        busy_d      = 1'b0;
        timer_clear = 1'b1;
        if (tx_start) begin
          shift_d = tx_data;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end

      DATA: begin
        if (bit_tick) begin
          shift_d   = shift_next;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d    = shift_next[0];
          end
        end
      end

      STOP: begin
        if (bit_tick) begin
          state_d   = IDLE;
          tx_d      = 1'b1;
          busy_d    = 1'b0;
          tx_done_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule
